// File: rtl/reg_write_port_pkg.sv
// rtl/reg_write_port_pkg.sv - shared register-file widths, forward-select codes and helpers
//
// Purpose : constants and types shared by the write port and the decode-stage
//           read ports. Widths and forward codes live only here.
// Contents: REG_DATA_WIDTH, REG_NUM_WIDTH, REG_FORWARD_WIDTH, NUM_REGISTERS,
//           reg_forward_e (REG_FORWARD_REG_FILE/WB/R0), rn_legal().
package reg_write_port_pkg;

  localparam int REG_DATA_WIDTH    = 16;
  localparam int REG_NUM_WIDTH     = 4;
  localparam int REG_FORWARD_WIDTH = 2;
  localparam int NUM_REGISTERS     = 16;

  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;
  typedef logic [REG_NUM_WIDTH-1:0]  reg_num_t;

  // 2'b11 is deliberately left unassigned; it is never driven.
  typedef enum logic [REG_FORWARD_WIDTH-1:0] {
    REG_FORWARD_REG_FILE = 2'b00,
    REG_FORWARD_WB       = 2'b01,
    REG_FORWARD_R0       = 2'b10
  } reg_forward_e;

  // True when rn addresses an implemented register.
  function automatic logic rn_legal(input reg_num_t rn, input int num_regs);
    return (32'(rn) < 32'(num_regs));
  endfunction

endpackage

// File: rtl/reg_write_port_if.sv
// rtl/reg_write_port_if.sv - write-back / read-port bus of the register file
//
// Purpose : bundles the WB-stage write request, the R0 auxiliary write, the
//           two read-port register numbers and everything handed back to the
//           read ports.
// Modports: master - WB stage / read ports (drive requests, observe results)
//           slave  - reg_write_port (consume requests, drive results)
interface reg_write_port_if;
  import reg_write_port_pkg::*;

  logic                         wb_en;
  reg_num_t                     wb_rn;
  reg_data_t                    wb_data;
  logic                         r0_en;
  reg_data_t                    r0_data;
  reg_num_t                     rn1;
  reg_num_t                     rn2;
  reg_data_t                    rfile_data1;
  reg_data_t                    rfile_data2;
  reg_data_t                    wrd;
  reg_data_t                    r0d;
  logic [REG_FORWARD_WIDTH-1:0] reg_forward1;
  logic [REG_FORWARD_WIDTH-1:0] reg_forward2;
  logic                         wr_exception;

  modport master (
    output wb_en, wb_rn, wb_data, r0_en, r0_data, rn1, rn2,
    input  rfile_data1, rfile_data2, wrd, r0d, reg_forward1, reg_forward2, wr_exception
  );

  modport slave (
    input  wb_en, wb_rn, wb_data, r0_en, r0_data, rn1, rn2,
    output rfile_data1, rfile_data2, wrd, r0d, reg_forward1, reg_forward2, wr_exception
  );

endinterface

// File: rtl/reg_write_port_fwd_select.sv
// rtl/reg_write_port_fwd_select.sv - per-read-port forward-source selector
//
// Purpose : decides whether a read port takes its operand from the register
//           file, the write-back bypass or the R0 auxiliary bypass.
// Ports   : i_rn          read-port register number
//           i_wb_en       general write request this cycle
//           i_wb_rn       general write destination
//           i_r0_en       auxiliary R0 write request
//           o_reg_forward selected source (reg_forward_e code)
module reg_write_port_fwd_select
  import reg_write_port_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGISTERS
) (
  input  reg_num_t                     i_rn,
  input  logic                         i_wb_en,
  input  reg_num_t                     i_wb_rn,
  input  logic                         i_r0_en,
  output logic [REG_FORWARD_WIDTH-1:0] o_reg_forward
);

  logic w_hit_r0;
  logic w_hit_wb;

  // R0 bypass outranks the general bypass: on an R0/WB collision the R0 data
  // is the value that actually lands in the register.
  assign w_hit_r0 = i_r0_en && (i_rn == '0);
  assign w_hit_wb = i_wb_en && (i_wb_rn == i_rn) && rn_legal(i_wb_rn, NUM_REGS);

  always_comb begin
    o_reg_forward = REG_FORWARD_REG_FILE;
    if (w_hit_r0) begin
      o_reg_forward = REG_FORWARD_R0;
    end else if (w_hit_wb) begin
      o_reg_forward = REG_FORWARD_WB;
    end
  end

endmodule

// File: rtl/reg_write_port.sv
// rtl/reg_write_port.sv - register-file storage, write-back port and read-port feeds
//
// Purpose : owns the NUM_REGS x REG_DATA_WIDTH storage, the R0 auxiliary
//           write path and the registered illegal-write flag; produces the
//           rfile_data / wrd / r0d / reg_forward set for both read ports.
// Ports   : clk  rising-edge clock
//           rst  synchronous active-high reset
//           bus  reg_write_port_if.slave (write requests in, read-port data out)
module reg_write_port
  import reg_write_port_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGISTERS
) (
  input logic              clk,
  input logic              rst,
  reg_write_port_if.slave  bus
);

  reg_data_t r_regs [NUM_REGS];
  logic      r_wr_exception;

  logic      w_wb_legal;
  logic      w_r0_collide;
  logic      w_wb_commit;
  logic      w_wr_illegal;
  reg_data_t w_rd1;
  reg_data_t w_rd2;

  assign w_wb_legal   = bus.wb_en && rn_legal(bus.wb_rn, NUM_REGS);
  // A general write aimed at R0 while the R0 path is active loses and is
  // reported as an illegal write.
  assign w_r0_collide = bus.wb_en && bus.r0_en && (bus.wb_rn == '0);
  assign w_wb_commit  = w_wb_legal && !w_r0_collide;
  assign w_wr_illegal = (bus.wb_en && !rn_legal(bus.wb_rn, NUM_REGS)) || w_r0_collide;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_exception <= 1'b0;
    end else begin
      r_wr_exception <= w_wr_illegal;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == 0 && bus.r0_en) begin
          r_regs[i] <= bus.r0_data;
        end else if (w_wb_commit && (bus.wb_rn == REG_NUM_WIDTH'(i))) begin
          r_regs[i] <= bus.wb_data;
        end
      end
    end
  end

  // Read mux by comparison rather than indexing so an out-of-range number
  // can never alias onto an implemented register; it simply reads 0.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (bus.rn1 == REG_NUM_WIDTH'(i)) begin
        w_rd1 = r_regs[i];
      end
      if (bus.rn2 == REG_NUM_WIDTH'(i)) begin
        w_rd2 = r_regs[i];
      end
    end
  end

  assign bus.rfile_data1  = w_rd1;
  assign bus.rfile_data2  = w_rd2;
  assign bus.wrd          = bus.wb_en ? bus.wb_data : '0;
  assign bus.r0d          = bus.r0_en ? bus.r0_data : '0;
  assign bus.wr_exception = r_wr_exception;

  reg_write_port_fwd_select #(
    .NUM_REGS (NUM_REGS)
  ) u_fwd1 (
    .i_rn          (bus.rn1),
    .i_wb_en       (bus.wb_en),
    .i_wb_rn       (bus.wb_rn),
    .i_r0_en       (bus.r0_en),
    .o_reg_forward (bus.reg_forward1)
  );

  reg_write_port_fwd_select #(
    .NUM_REGS (NUM_REGS)
  ) u_fwd2 (
    .i_rn          (bus.rn2),
    .i_wb_en       (bus.wb_en),
    .i_wb_rn       (bus.wb_rn),
    .i_r0_en       (bus.r0_en),
    .o_reg_forward (bus.reg_forward2)
  );

endmodule
